ps2_receptor: RTL and testbench
===============================

Name: ps2_receptor

Overview:
- Device-to-host PS/2 frame receiver; the downstream companion of the PS/2 host transmitter on the same ps2_c/ps2_d pair.
- After the transmitter sends a command (e.g. 0xF4), this block captures the device's 11-bit response frames (ACK 0xFA, then data packets).
- It delivers each byte with parity and framing status to the controller logic.
- It only listens; the bidirectional line drivers belong to the transmitter.

Parameters:
- FILTER_LEN, 8: number of consecutive identical synchronized samples required to change the filtered ps2_c level.
- TIMEOUT_CYC, 100000: clk cycles without a falling edge mid-frame before the frame is aborted (2 ms at 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous active-low reset.
- ps2_c  in  1  PS/2 clock line, asynchronous.
- ps2_d  in  1  PS/2 data line, asynchronous.
- rx_en  in  1  receive enable; tie to the transmitter's tx_idle.
- rx_data  out  8  last received byte.
- rx_done  out  1  one-cycle pulse, frame complete.
- rx_parity_err  out  1  parity status of the last frame; valid while rx_done is high, held afterwards.
- rx_frame_err  out  1  start/stop bit status of the last frame; valid while rx_done is high, held afterwards.
- rx_timeout  out  1  one-cycle pulse, frame aborted by watchdog.
- rx_busy  out  1  high while a frame is in progress.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, state IDLE, counters 0, filtered clock = 1, sync flops = 1.
- Input conditioning:
  - ps2_c and ps2_d each pass through a 2-flop synchronizer.
  - Filtered clock goes 0 only after FILTER_LEN consecutive 0 samples, and 1 only after FILTER_LEN consecutive 1 samples; otherwise it holds.
  - Falling edge (fall) = registered filtered clock 1 -> 0, a one-cycle strobe.
- States IDLE, RECV:
  - IDLE: on fall with rx_en=1, shift in synced ps2_d as bit 0 (start), bitcnt=1, go to RECV, rx_busy=1. A fall with rx_en=0 is ignored.
  - RECV: on each fall, shift synced ps2_d into an 11-bit shift register (LSB first), bitcnt+1.
  - When bitcnt reaches 11, in the next cycle:
    - rx_done=1 for exactly one cycle.
    - rx_data = bits[8:1].
    - rx_parity_err = 1 if the XOR of bits[9:1] is 0 (odd parity required).
    - rx_frame_err = 1 if bit0≠0 or bit10≠1.
    - Return to IDLE, rx_busy=0.
  - rx_data and both error flags update even when an error is flagged, and hold until the next rx_done.
- Watchdog:
  - In RECV, the counter clears on every fall and increments otherwise.
  - At TIMEOUT_CYC: rx_timeout=1 for one cycle, go to IDLE, discard the partial frame. rx_data and the error flags are unchanged, and no rx_done is issued.
- rx_en=0 while in RECV: abort to IDLE in the next cycle, with no rx_done and no rx_timeout. rx_en=0 takes priority over a simultaneous fall.
- Simultaneous watchdog expiry and fall: the fall wins and the counter clears.
- Latency: ps2_c pin edge -> fall = 2 + FILTER_LEN + 1 cycles; 11th fall -> rx_done = 1 cycle.
- Glitches on ps2_c shorter than FILTER_LEN cycles produce no fall.

Decomposition:
- Shared package ps2_pkg:
  - Frame constants: FRAME_BITS=11, START_BIT=0, STOP_BIT=1.
  - Default FILTER_LEN and TIMEOUT_CYC.
  - Device reply codes ACK=8'hFA, RESEND=8'hFE, BAT_OK=8'hAA.
  - The transmitter uses the same package.
- One sub-module: ps2_filtro. It holds the synchronizer, the FILTER_LEN debounce on ps2_c, and the fall strobe. It is reusable by the transmitter for its clock sensing.

Test Plan (bench: 20 ns clk, PS/2 clock period 20 us, data changed mid-high, device-driven):
- Frame 0xFA, parity 1, stop 1, rx_en=1 -> one rx_done pulse; rx_data=0xFA, parity_err=0, frame_err=0; rx_busy low after.
- Back-to-back frames 0xAA (parity 1) then 0x01 (parity 0), 50 us gap -> two rx_done pulses, rx_data 0xAA then 0x01, no errors.
- Frame 0xFA with parity 0 -> rx_done, rx_data=0xFA, parity_err=1. Next frame 0x00 with stop bit 0 -> frame_err=1, parity_err=0.
- Send start plus 4 data bits, hold ps2_c high 2.1 ms -> one rx_timeout pulse, no rx_done, rx_busy=0. Then full 0xAA -> received cleanly.
- 100 ns low pulses on ps2_c while idle, and rx_en=0 during a full 0xF4-length frame -> no rx_done, rx_busy stays 0.
- Assert rst=0 after 6 bits of a frame, release, then send 0xFA -> outputs 0 during reset; 0xFA then received correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions used by the receiver, the transmitter and the input filter.
package ps2_pkg;

    // Frame layout: start, 8 data bits LSB first, odd parity, stop.
    localparam int   FRAME_BITS = 11;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

    // Default conditioning and watchdog settings for a 50 MHz system clock.
    localparam int DEF_FILTER_LEN  = 8;
    localparam int DEF_TIMEOUT_CYC = 100000;

    // Common device reply codes.
    localparam logic [7:0] ACK    = 8'hFA;
    localparam logic [7:0] RESEND = 8'hFE;
    localparam logic [7:0] BAT_OK = 8'hAA;

    // Receiver states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } rx_state_e;

    // Odd parity holds when data plus parity bit contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/ps2_filtro.sv
// PS/2 line conditioning: two-flop synchronizers, clock debounce, falling-edge strobe.
module ps2_filtro
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = DEF_FILTER_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_c,
    input  logic ps2_d,
    output logic c_filt,
    output logic d_sync,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          c_meta_q;
    logic          c_sync_q;
    logic          d_meta_q;
    logic          d_sync_q;
    logic          c_filt_q;
    logic          c_filt_d;
    logic          c_prev_q;
    logic [CW-1:0] run_q;
    logic [CW-1:0] run_d;

    // Bring both asynchronous lines into the clk domain; idle bus level is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_meta_q <= 1'b1;
            c_sync_q <= 1'b1;
            d_meta_q <= 1'b1;
            d_sync_q <= 1'b1;
        end else begin
            c_meta_q <= ps2_c;
            c_sync_q <= c_meta_q;
            d_meta_q <= ps2_d;
            d_sync_q <= d_meta_q;
        end
    end

    // Count consecutive samples disagreeing with the filtered level; flip after FILTER_LEN of them.
    always_comb begin
        c_filt_d = c_filt_q;
        run_d    = '0;
        if (c_sync_q != c_filt_q) begin
            if (run_q == CW'(FILTER_LEN - 1)) begin
                c_filt_d = c_sync_q;
            end else begin
                run_d = run_q + CW'(1);
            end
        end
    end

    // Filtered level, its one-cycle-delayed copy for edge detection, and the run counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_filt_q <= 1'b1;
            c_prev_q <= 1'b1;
            run_q    <= '0;
        end else begin
            c_filt_q <= c_filt_d;
            c_prev_q <= c_filt_q;
            run_q    <= run_d;
        end
    end

    assign c_filt = c_filt_q;
    assign d_sync = d_sync_q;
    assign fall   = c_prev_q & ~c_filt_q;

endmodule

// File: rtl/ps2_receptor.sv
// Device-to-host PS/2 frame receiver with parity/framing status and a mid-frame watchdog.
module ps2_receptor
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = DEF_FILTER_LEN,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_c,
    input  logic       ps2_d,
    input  logic       rx_en,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_parity_err,
    output logic       rx_frame_err,
    output logic       rx_timeout,
    output logic       rx_busy
);

    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    localparam int BW = $clog2(FRAME_BITS + 1);

    logic                  c_filt;
    logic                  d_sync;
    logic                  fall;

    rx_state_e             state_q;
    rx_state_e             state_d;
    logic [FRAME_BITS-1:0] shreg_q;
    logic [FRAME_BITS-1:0] shreg_d;
    logic [BW-1:0]         bitcnt_q;
    logic [BW-1:0]         bitcnt_d;
    logic [WW-1:0]         wdog_q;
    logic [WW-1:0]         wdog_d;
    logic [7:0]            data_q;
    logic [7:0]            data_d;
    logic                  perr_q;
    logic                  perr_d;
    logic                  ferr_q;
    logic                  ferr_d;
    logic                  done_q;
    logic                  done_d;
    logic                  tmo_q;
    logic                  tmo_d;

    logic [FRAME_BITS-1:0] frame_next;
    logic                  start_ev;
    logic                  abort_ev;
    logic                  bit_ev;
    logic                  last_ev;
    logic                  expire_ev;

    ps2_filtro #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filtro (
        .clk    (clk),
        .rst    (rst),
        .ps2_c  (ps2_c),
        .ps2_d  (ps2_d),
        .c_filt (c_filt),
        .d_sync (d_sync),
        .fall   (fall)
    );

    // Bits arrive LSB first, so each new bit enters at the top and the start bit ends up in bit 0.
    assign frame_next = {d_sync, shreg_q[FRAME_BITS-1:1]};
    assign start_ev   = (state_q == ST_IDLE) && rx_en && fall;
    assign abort_ev   = (state_q == ST_RECV) && !rx_en;
    assign bit_ev     = (state_q == ST_RECV) && rx_en && fall;
    assign last_ev    = bit_ev && (bitcnt_q == BW'(FRAME_BITS - 1));
    assign expire_ev  = (state_q == ST_RECV) && rx_en && !fall && (wdog_q == WW'(TIMEOUT_CYC));

    // State register plus frame datapath and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            wdog_q   <= '0;
            data_q   <= '0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            done_q   <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            wdog_q   <= wdog_d;
            data_q   <= data_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            done_q   <= done_d;
            tmo_q    <= tmo_d;
        end
    end

    // Next state: disable beats a fall, a fall beats watchdog expiry, the 11th fall closes the frame.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        wdog_d   = wdog_q;
        unique case (state_q)
            ST_IDLE: begin
                bitcnt_d = '0;
                wdog_d   = '0;
                if (start_ev) begin
                    shreg_d  = frame_next;
                    bitcnt_d = BW'(1);
                    state_d  = ST_RECV;
                end
            end
            ST_RECV: begin
                if (abort_ev) begin
                    state_d  = ST_IDLE;
                    bitcnt_d = '0;
                    wdog_d   = '0;
                end else if (bit_ev) begin
                    shreg_d = frame_next;
                    wdog_d  = '0;
                    if (last_ev) begin
                        state_d  = ST_IDLE;
                        bitcnt_d = '0;
                    end else begin
                        bitcnt_d = bitcnt_q + BW'(1);
                    end
                end else if (expire_ev) begin
                    state_d  = ST_IDLE;
                    bitcnt_d = '0;
                    wdog_d   = '0;
                end else begin
                    wdog_d = wdog_q + WW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs: strobes for completion and timeout, byte and status captured only on completion.
    always_comb begin
        done_d = last_ev;
        tmo_d  = expire_ev;
        data_d = data_q;
        perr_d = perr_q;
        ferr_d = ferr_q;
        if (last_ev) begin
            data_d = frame_next[8:1];
            perr_d = ~odd_parity_ok(frame_next[9:1]);
            ferr_d = (frame_next[0] != START_BIT) || (frame_next[FRAME_BITS-1] != STOP_BIT);
        end
    end

    assign rx_data       = data_q;
    assign rx_done       = done_q;
    assign rx_parity_err = perr_q;
    assign rx_frame_err  = ferr_q;
    assign rx_timeout    = tmo_q;
    assign rx_busy       = (state_q == ST_RECV);

endmodule

// File: tb/tb_ps2_receptor.sv
// Directed bench for ps2_receptor: a device model drives frames on ps2_c/ps2_d.
// The PS/2 clock and watchdog are scaled down so the whole run stays short.
module tb_ps2_receptor;

    localparam int FLEN = 8;
    localparam int TMO  = 3000;
    localparam int HALF = 40;
    localparam int GAP  = 200;

    logic       clk;
    logic       rst;
    logic       ps2_c;
    logic       ps2_d;
    logic       rx_en;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_parity_err;
    logic       rx_frame_err;
    logic       rx_timeout;
    logic       rx_busy;

    int checks = 0;
    int errors = 0;

    int done_total = 0;
    int tmo_total  = 0;
    int busy_total = 0;

    int done_snap;
    int tmo_snap;
    int busy_snap;

    typedef struct {
        logic [7:0] data;
        logic       start;
        logic       par;
        logic       stop;
        logic       en;
        int         exp_done;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs [7];

    ps2_receptor #(
        .FILTER_LEN  (FLEN),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ps2_c         (ps2_c),
        .ps2_d         (ps2_d),
        .rx_en         (rx_en),
        .rx_data       (rx_data),
        .rx_done       (rx_done),
        .rx_parity_err (rx_parity_err),
        .rx_frame_err  (rx_frame_err),
        .rx_timeout    (rx_timeout),
        .rx_busy       (rx_busy)
    );

    // 50 MHz system clock.
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Cumulative pulse and busy counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (rx_done)    done_total = done_total + 1;
        if (rx_timeout) tmo_total  = tmo_total + 1;
        if (rx_busy)    busy_total = busy_total + 1;
    end

    function automatic logic [10:0] make_frame(input logic [7:0] data, input logic start,
                                               input logic par, input logic stop);
        return {stop, par, data, start};
    endfunction

    // Device model: data changes mid-high, then the clock pulses low for half a period.
    task automatic send_bits(input logic [10:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_d = frame[i];
            repeat (HALF / 2) @(negedge clk);
            ps2_c = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_c = 1'b1;
            repeat (HALF / 2) @(negedge clk);
        end
    endtask

    task automatic snapshot();
        done_snap = done_total;
        tmo_snap  = tmo_total;
        busy_snap = busy_total;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rx_en = v.en;
        snapshot();
        send_bits(make_frame(v.data, v.start, v.par, v.stop), 11);
        repeat (GAP) @(negedge clk);
        rx_en = 1'b1;
    endtask

    initial begin
        // Frame table: {data, start, parity, stop, rx_en, #done, data, parity_err, frame_err}.
        vecs[0] = '{8'hFA, 1'b0, 1'b1, 1'b1, 1'b1, 1, 8'hFA, 1'b0, 1'b0};
        vecs[1] = '{8'hAA, 1'b0, 1'b1, 1'b1, 1'b1, 1, 8'hAA, 1'b0, 1'b0};
        vecs[2] = '{8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 1, 8'h01, 1'b0, 1'b0};
        vecs[3] = '{8'hFA, 1'b0, 1'b0, 1'b1, 1'b1, 1, 8'hFA, 1'b1, 1'b0};
        vecs[4] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1, 8'h00, 1'b0, 1'b1};
        vecs[5] = '{8'hF4, 1'b0, 1'b0, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b1};
        vecs[6] = '{8'h55, 1'b1, 1'b1, 1'b1, 1'b1, 1, 8'h55, 1'b0, 1'b1};

        ps2_c = 1'b1;
        ps2_d = 1'b1;
        rx_en = 1'b1;
        rst   = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("reset rx_data", 32'(rx_data), 32'h00);
        checkOutput("reset rx_done", 32'(rx_done), 32'h0);
        checkOutput("reset parity_err", 32'(rx_parity_err), 32'h0);
        checkOutput("reset frame_err", 32'(rx_frame_err), 32'h0);
        checkOutput("reset rx_timeout", 32'(rx_timeout), 32'h0);
        checkOutput("reset rx_busy", 32'(rx_busy), 32'h0);
        rst = 1'b1;
        repeat (20) @(negedge clk);

        // Short glitches on ps2_c while idle must not start a frame.
        snapshot();
        for (int g = 0; g < 5; g++) begin
            ps2_c = 1'b0;
            repeat (5) @(negedge clk);
            ps2_c = 1'b1;
            repeat (20) @(negedge clk);
        end
        repeat (GAP) @(negedge clk);
        checkOutput("glitch done count", 32'(done_total - done_snap), 32'd0);
        checkOutput("glitch busy cycles", 32'(busy_total - busy_snap), 32'd0);

        for (int k = 0; k < 7; k++) begin
            applyStimulus(vecs[k]);
            $display("[TB] vector %0d applied", k);
            checkOutput("vec done count", 32'(done_total - done_snap), 32'(vecs[k].exp_done));
            checkOutput("vec timeout count", 32'(tmo_total - tmo_snap), 32'd0);
            checkOutput("vec rx_data", 32'(rx_data), 32'(vecs[k].exp_data));
            checkOutput("vec parity_err", 32'(rx_parity_err), 32'(vecs[k].exp_perr));
            checkOutput("vec frame_err", 32'(rx_frame_err), 32'(vecs[k].exp_ferr));
            checkOutput("vec busy after", 32'(rx_busy), 32'h0);
            checkOutput("vec busy seen", 32'((busy_total - busy_snap) > 0), 32'(vecs[k].en));
        end

        // Partial frame then silence: one watchdog pulse, nothing delivered, status held.
        snapshot();
        send_bits(make_frame(8'hAA, 1'b0, 1'b1, 1'b1), 5);
        repeat (TMO + 1000) @(negedge clk);
        checkOutput("timeout pulses", 32'(tmo_total - tmo_snap), 32'd1);
        checkOutput("timeout done count", 32'(done_total - done_snap), 32'd0);
        checkOutput("timeout busy", 32'(rx_busy), 32'h0);
        checkOutput("timeout rx_data held", 32'(rx_data), 32'h55);
        checkOutput("timeout frame_err held", 32'(rx_frame_err), 32'h1);

        snapshot();
        send_bits(make_frame(8'hAA, 1'b0, 1'b1, 1'b1), 11);
        repeat (GAP) @(negedge clk);
        checkOutput("post-timeout done", 32'(done_total - done_snap), 32'd1);
        checkOutput("post-timeout rx_data", 32'(rx_data), 32'hAA);
        checkOutput("post-timeout parity_err", 32'(rx_parity_err), 32'h0);
        checkOutput("post-timeout frame_err", 32'(rx_frame_err), 32'h0);
        checkOutput("post-timeout timeouts", 32'(tmo_total - tmo_snap), 32'd0);

        // Reset in the middle of a frame clears everything; the next frame is clean.
        send_bits(make_frame(8'hFA, 1'b0, 1'b1, 1'b1), 6);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("midreset rx_data", 32'(rx_data), 32'h00);
        checkOutput("midreset rx_busy", 32'(rx_busy), 32'h0);
        checkOutput("midreset rx_done", 32'(rx_done), 32'h0);
        checkOutput("midreset rx_timeout", 32'(rx_timeout), 32'h0);
        rst = 1'b1;
        repeat (50) @(negedge clk);
        snapshot();
        send_bits(make_frame(8'hFA, 1'b0, 1'b1, 1'b1), 11);
        repeat (GAP) @(negedge clk);
        checkOutput("after reset done", 32'(done_total - done_snap), 32'd1);
        checkOutput("after reset rx_data", 32'(rx_data), 32'hFA);
        checkOutput("after reset parity_err", 32'(rx_parity_err), 32'h0);
        checkOutput("after reset frame_err", 32'(rx_frame_err), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
